// File: rtl/msg_packer_top.sv
// Packs length-prefixed messages into a 64-bit Avalon-ST byte stream.
// A 48-byte shift buffer feeds out_data directly from its first eight registers.
module msg_packer_top (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [255:0] in_data,
    input  logic [5:0]   in_length,
    input  logic         in_sop,
    input  logic         in_eop,
    input  logic [15:0]  in_count,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [63:0]  out_data,
    output logic         out_startofpacket,
    output logic         out_endofpacket,
    output logic [2:0]   out_empty,
    output logic         out_error
);
    typedef enum logic {PKT_IDLE, PKT_OPEN} pkt_state_t;

    localparam int unsigned BUF_BYTES = 48;
    localparam int unsigned APP_BYTES = 36;

    pkt_state_t  state_q;
    logic [7:0]  buf_q [BUF_BYTES];
    logic [7:0]  buf_d [BUF_BYTES];
    logic [7:0]  app   [APP_BYTES];
    logic [7:0]  pay   [32];
    logic [5:0]  level_q, level_d;
    logic [15:0] msg_cnt_q, exp_cnt_q;
    logic        err_q, err_d, eop_pend_q, sop_pend_q;
    logic        msg_take, beat_take, keep, drop, len_bad, cnt_bad;
    logic [5:0]  len_field;
    logic [15:0] cnt_next, cnt_expect;
    int unsigned app_n, pos, pop_n;

    for (genvar g = 0; g < 32; g++) begin : g_pay
        assign pay[g] = in_data[255-8*g -: 8];
    end

    for (genvar g = 0; g < 8; g++) begin : g_out
        assign out_data[63-8*g -: 8] = buf_q[g];
    end

    always_comb begin
        in_ready          = !reset_n && (level_q <= 6'd12) && !eop_pend_q &&
                            (!in_sop || level_q == '0);
        out_valid         = (level_q >= 6'd8) || (eop_pend_q && level_q != '0);
        out_endofpacket   = eop_pend_q && (level_q != '0) && (level_q <= 6'd8);
        out_empty         = out_endofpacket ? 3'(4'd8 - level_q[3:0]) : '0;
        out_error         = out_endofpacket && err_q;
        out_startofpacket = sop_pend_q;
    end

    always_comb begin
        msg_take   = in_valid && in_ready;
        beat_take  = out_valid && out_ready;
        keep       = msg_take && (in_sop || state_q == PKT_OPEN);
        drop       = msg_take && !keep;
        len_bad    = (in_length == '0) || (in_length > 6'd32);
        len_field  = (in_length > 6'd32) ? 6'd32 : in_length;
        cnt_next   = in_sop ? 16'd1 : msg_cnt_q + 16'd1;
        cnt_expect = in_sop ? in_count : exp_cnt_q;
        cnt_bad    = in_eop && (cnt_next != cnt_expect);
        app_n      = (in_sop ? 32'd4 : 32'd2) + 32'(len_field);
        pop_n      = beat_take ? ((level_q >= 6'd8) ? 32'd8 : 32'(level_q)) : 32'd0;
        pos        = 32'(level_q) - pop_n;
        level_d    = level_q - 6'(pop_n) + (keep ? 6'(app_n) : 6'd0);

        for (int unsigned j = 0; j < APP_BYTES; j++) begin
            app[j] = '0;
            if (in_sop) begin
                if (j == 0)      app[j] = in_count[15:8];
                else if (j == 1) app[j] = in_count[7:0];
                else if (j == 3) app[j] = {2'b00, len_field};
                else if (j >= 4) app[j] = pay[5'(j-4)];
            end else begin
                if (j == 1)                app[j] = {2'b00, len_field};
                else if (j >= 2 && j < 34) app[j] = pay[5'(j-2)];
            end
        end

        // Pop first, then append at the post-pop level; bytes past level stay zero,
        // which gives the zero padding on a short eop beat for free.
        for (int unsigned j = 0; j < BUF_BYTES; j++) begin
            if (!beat_take)
                buf_d[j] = buf_q[j];
            else if (j + 8 < BUF_BYTES)
                buf_d[j] = buf_q[6'(j+8)];
            else
                buf_d[j] = '0;
            if (keep && j >= pos && j < pos + app_n)
                buf_d[j] = app[6'(j-pos)];
        end

        err_d = err_q;
        if (beat_take && out_endofpacket)
            err_d = 1'b0;
        if (drop || (keep && (len_bad || cnt_bad)))
            err_d = 1'b1;
    end

    always_ff @(posedge clk or posedge reset_n) begin
        if (reset_n) begin
            state_q    <= PKT_IDLE;
            buf_q      <= '{default: '0};
            level_q    <= '0;
            msg_cnt_q  <= '0;
            exp_cnt_q  <= '0;
            err_q      <= 1'b0;
            eop_pend_q <= 1'b0;
            sop_pend_q <= 1'b0;
        end else begin
            buf_q   <= buf_d;
            level_q <= level_d;
            err_q   <= err_d;
            if (keep) begin
                msg_cnt_q <= cnt_next;
                if (in_sop)
                    exp_cnt_q <= in_count;
                state_q <= in_eop ? PKT_IDLE : PKT_OPEN;
            end
            if (keep && in_eop)
                eop_pend_q <= 1'b1;
            else if (beat_take && out_endofpacket)
                eop_pend_q <= 1'b0;
            if (keep && in_sop)
                sop_pend_q <= 1'b1;
            else if (beat_take)
                sop_pend_q <= 1'b0;
        end
    end
endmodule

// File: doc/msg_packer_top.md
MSG_PACKER_TOP -- requirements
Module: msg_packer_top

Interface
REQ-001 The block SHALL have no parameters; all widths are fixed as listed below.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 reset_n  input  1  reset, asynchronous, active-high.
REQ-004 in_valid  input  1  message valid on the input side.
REQ-005 in_ready  output  1  block can accept a message this cycle.
REQ-006 in_data  input  256  message payload; byte i at in_data[255-8i -: 8], i=0 first on the wire.
REQ-007 in_length  input  6  payload length in bytes, legal 1..32.
REQ-008 in_sop  input  1  first message of a packet; qualifies in_count.
REQ-009 in_eop  input  1  last message of a packet; may coincide with in_sop.
REQ-010 in_count  input  16  number of messages in the packet; sampled only with in_sop.
REQ-011 out_valid  output  1  Avalon-ST beat valid.
REQ-012 out_ready  input  1  downstream accepts beat.
REQ-013 out_data  output  64  beat data, first wire byte in out_data[63:56].
REQ-014 out_startofpacket  output  1  first beat of packet.
REQ-015 out_endofpacket  output  1  last beat of packet.
REQ-016 out_empty  output  3  unused trailing bytes on the eop beat, 0 elsewhere.
REQ-017 out_error  output  1  packet error, valid on the eop beat only.

Function
REQ-018 Wire format SHALL be: 2-byte big-endian in_count, then per message a 2-byte big-endian length followed by the payload bytes, packed contiguously with no padding across messages or beats.
REQ-019 The block SHALL hold a 48-byte byte buffer with a level counter 0..48; out_data SHALL be buffer bytes 0..7, driven from registers.
REQ-020 A message SHALL transfer on in_valid & in_ready; a beat SHALL transfer on out_valid & out_ready; both may occur in the same cycle.
REQ-021 in_ready SHALL be 1 iff level <= 12 and no eop is pending, and additionally level == 0 when in_sop is presented (a new packet starts only after the previous eop beat is sent).
REQ-022 Next level SHALL be level - 8*(beat taken) + 2*(sop taken) + 2 + encoded_len (message taken), with the pop shift applied before the append.
REQ-023 Bytes of an accepted message SHALL be visible in the buffer in the next cycle (one-cycle input-to-output latency when level reaches 8).
REQ-024 out_valid SHALL be 1 iff level >= 8, or eop is pending and level > 0.
REQ-025 out_startofpacket SHALL be 1 on the first beat after an accepted in_sop, and 0 on all other beats.
REQ-026 out_endofpacket SHALL be 1 iff eop is pending and level <= 8; out_empty SHALL then be 8 - level, and unused bytes SHALL be 0x00.
REQ-027 The eop-pending flag SHALL set when in_eop is taken and clear when the eop beat transfers.
REQ-028 While out_valid = 1 and out_ready = 0, out_data, out_startofpacket, out_endofpacket, out_empty and out_error SHALL hold stable.
REQ-029 The block SHALL count the messages accepted in a packet (16-bit).
  - If the count at eop differs from in_count, it SHALL set the error flag.
REQ-030 in_length == 0 SHALL encode a length field of 0x0000 with no payload and set the error flag.
REQ-031 in_length > 32 SHALL encode a length field of 0x0020 with 32 payload bytes and set the error flag.
REQ-032 A message presented with in_sop = 0 while no packet is open SHALL be accepted, dropped (no bytes written), and set the error flag of the next packet.
REQ-033 out_error SHALL equal the error flag on the eop beat and 0 elsewhere; the flag SHALL clear after the eop beat transfers.

Reset
REQ-034 While reset_n = 1, the block SHALL clear level, message counter, error flag, eop-pending and sop-pending.
REQ-035 During reset, out_valid, in_ready, out_startofpacket, out_endofpacket, out_error SHALL be 0, and out_empty and out_data SHALL be 0.
REQ-036 Reset mid-packet SHALL discard all buffered bytes; after release, the first accepted message SHALL require in_sop.

Verification
REQ-037 8 messages, count 8, out_ready=1:
  - messages: 8x62, 12x68, 10x70, 15x7a, 14x4d, 17x38, 11x31, 9x5a.
  - -> 15 beats; first 0x0008000862626262 with sop; 4th 0x6868000a70707070.
  - -> last 0x5a5a000000000000 with eop, empty=6, error=0.
REQ-038 Single message, sop+eop, count 1, length 1, byte 0x41 -> one beat 0x0001000141000000, sop=eop=1, empty=3.
REQ-039 Same as REQ-037 with out_ready toggled 3 low / 1 high -> identical beat sequence; beats stable while stalled; in_ready drops while level > 12.
REQ-040 Count 2 with eop on the first message (length 4) -> eop beat out_error=1; the next packet's eop beat out_error=0.
REQ-041 in_length=40, count 1, sop+eop -> length field 0x0020, 36 bytes total, 5 beats, empty=4, out_error=1.
REQ-042 Reset asserted after 3 beats of REQ-037 -> out_valid=0 immediately; a new sop packet after release starts with 0x0008 header.
